// File: rtl/resend_scheduler.sv
// resend_scheduler: tracks four in-flight packet slots, schedules resends on NACK/timeout and abandons after max retries
module resend_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES = 3,
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       alloc_req,
  output logic       alloc_gnt,
  output logic [1:0] alloc_slot,
  input  logic       ack_valid,
  input  logic [1:0] ack_slot,
  input  logic       nack_valid,
  input  logic [1:0] nack_slot,
  input  logic [3:0] rs_cnt_full,
  output logic [3:0] rs_write,
  output logic [3:0] slot_busy,
  output logic       err_valid,
  output logic [1:0] err_slot
);
  typedef enum logic [1:0] {FREE, WAIT_ACK, RESEND_PEND} state_t;
  localparam logic [TIMER_W-1:0] T_LOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [1:0] R_MAX = 2'(MAX_RETRIES);

  state_t st [4];
  state_t st_n [4];
  logic [TIMER_W-1:0] tmr [4];
  logic [TIMER_W-1:0] tmr_n [4];
  logic [1:0] rty [4];
  logic [1:0] rty_n [4];
  logic [1:0] rr, rr_n, low, sel;
  logic [3:0] free, cand, rs_write_n;
  logic sel_any, sel_ack, abandon;

  assign slot_busy = ~free;
  assign alloc_gnt = nRST && alloc_req && |free;
  assign alloc_slot = alloc_gnt ? low : 2'd0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      free[i] = st[i] == FREE;
      cand[i] = st[i] == RESEND_PEND && !rs_cnt_full[i];
    end
    low = 2'd0;
    for (int i = 3; i >= 0; i--) if (free[i]) low = 2'(i);
    // descending walk leaves the first candidate at or after rr as the winner
    sel_any = 1'b0;
    sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (cand[rr + 2'(k)]) begin
        sel_any = 1'b1;
        sel = rr + 2'(k);
      end
    end
    sel_ack = sel_any && ack_valid && ack_slot == sel;
    abandon = sel_any && !sel_ack && rty[sel] == R_MAX;
    rs_write_n = (sel_any && !sel_ack && !abandon) ? 4'b0001 << sel : 4'b0000;
    rr_n = sel_any ? sel + 2'd1 : rr;
    for (int i = 0; i < 4; i++) begin
      st_n[i] = st[i];
      tmr_n[i] = tmr[i];
      rty_n[i] = rty[i];
      if (alloc_gnt && alloc_slot == 2'(i)) begin
        st_n[i] = WAIT_ACK;
        tmr_n[i] = T_LOAD;
        rty_n[i] = 2'd0;
      end else if (st[i] == WAIT_ACK) begin
        tmr_n[i] = tmr[i] - 1'b1;
        if (ack_valid && ack_slot == 2'(i)) begin
          st_n[i] = FREE;
          tmr_n[i] = '0;
          rty_n[i] = 2'd0;
        end else if ((nack_valid && nack_slot == 2'(i)) || tmr[i] == TIMER_W'(1)) begin
          st_n[i] = RESEND_PEND;
        end
      end else if (st[i] == RESEND_PEND) begin
        if ((ack_valid && ack_slot == 2'(i)) || (abandon && sel == 2'(i))) begin
          st_n[i] = FREE;
          tmr_n[i] = '0;
          rty_n[i] = 2'd0;
        end else if (sel_any && sel == 2'(i)) begin
          st_n[i] = WAIT_ACK;
          tmr_n[i] = T_LOAD;
          rty_n[i] = rty[i] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= FREE;
        tmr[i] <= '0;
        rty[i] <= 2'd0;
      end
      rr <= 2'd0;
      rs_write <= 4'b0000;
      err_valid <= 1'b0;
      err_slot <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= st_n[i];
        tmr[i] <= tmr_n[i];
        rty[i] <= rty_n[i];
      end
      rr <= rr_n;
      rs_write <= rs_write_n;
      err_valid <= abandon;
      err_slot <= abandon ? sel : 2'd0;
    end
  end
endmodule

// File: tb/tb_resend_scheduler.sv
// tb_resend_scheduler: random stimulus against a deadline-based slot model, scoreboard of expected resend/error pulses
module tb_resend_scheduler;
  localparam int T = 8;
  localparam int MR = 3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic alloc_req = 1'b0, ack_valid = 1'b0, nack_valid = 1'b0;
  logic [1:0] ack_slot = 2'd0, nack_slot = 2'd0;
  logic [3:0] rs_cnt_full = 4'd0;
  logic alloc_gnt, err_valid;
  logic [1:0] alloc_slot, err_slot;
  logic [3:0] rs_write, slot_busy;

  resend_scheduler #(.TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)) dut (
    .CLK(CLK), .nRST(nRST),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_slot(alloc_slot),
    .ack_valid(ack_valid), .ack_slot(ack_slot),
    .nack_valid(nack_valid), .nack_slot(nack_slot),
    .rs_cnt_full(rs_cnt_full), .rs_write(rs_write), .slot_busy(slot_busy),
    .err_valid(err_valid), .err_slot(err_slot)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {int due; logic [3:0] rs; logic err; logic [1:0] es;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0;

  // model: 0 free, 1 awaiting ack (expires at cycle dl), 2 resend pending
  int mst[4], dl[4], tries[4], ptr;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", n, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      mst[s] = 0;
      dl[s] = 0;
      tries[s] = 0;
    end
    ptr = 0;
  endtask

  always @(negedge CLK) begin
    ev_t e;
    if (nRST) begin
      e = '{0, 4'b0, 1'b0, 2'b0};
      if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
      chk("rs_write", rs_write, e.rs);
      chk("err_valid", err_valid, e.err);
      if (e.err) chk("err_slot", err_slot, e.es);
    end
  end

  task automatic step(input logic a, input logic av, input logic [1:0] as_, input logic nv,
                      input logic [1:0] ns, input logic [3:0] f);
    logic eg;
    logic [1:0] gs;
    logic [3:0] busy;
    int win, s;
    ev_t e;
    @(posedge CLK);
    #2;
    for (int i = 0; i < 4; i++) busy[i] = mst[i] != 0;
    chk("slot_busy", slot_busy, busy);
    alloc_req = a; ack_valid = av; ack_slot = as_;
    nack_valid = nv; nack_slot = ns; rs_cnt_full = f;
    eg = 1'b0;
    gs = 2'd0;
    for (int i = 3; i >= 0; i--) if (a && mst[i] == 0) begin eg = 1'b1; gs = 2'(i); end
    #1;
    chk("alloc_gnt", alloc_gnt, eg);
    chk("alloc_slot", alloc_slot, gs);
    win = -1;
    for (int k = 0; k < 4; k++) begin
      s = (ptr + k) % 4;
      if (win < 0 && mst[s] == 2 && !f[s]) win = s;
    end
    if (win >= 0) ptr = (win + 1) % 4;
    e = '{cyc + 1, 4'b0, 1'b0, 2'b0};
    for (int i = 0; i < 4; i++) begin
      if (eg && gs == 2'(i)) begin
        mst[i] = 1; dl[i] = cyc + T; tries[i] = 0;
      end else if (mst[i] == 1) begin
        if (av && as_ == 2'(i)) mst[i] = 0;
        else if ((nv && ns == 2'(i)) || cyc == dl[i]) mst[i] = 2;
      end else if (mst[i] == 2) begin
        if (av && as_ == 2'(i)) mst[i] = 0;
        else if (i == win && tries[i] < MR) begin
          mst[i] = 1; dl[i] = cyc + T; tries[i]++; e.rs[i] = 1'b1;
        end else if (i == win) begin
          mst[i] = 0; e.err = 1'b1; e.es = 2'(i);
        end
      end
    end
    if (e.rs != 0 || e.err) q.push_back(e);
  endtask

  task automatic check_zero(input string n);
    chk({n, "_rs_write"}, rs_write, 0);
    chk({n, "_err_valid"}, err_valid, 0);
    chk({n, "_err_slot"}, err_slot, 0);
    chk({n, "_slot_busy"}, slot_busy, 0);
    chk({n, "_alloc_gnt"}, alloc_gnt, 0);
    chk({n, "_alloc_slot"}, alloc_slot, 0);
  endtask

  initial begin
    logic [3:0] f;
    model_reset();
    #1;
    alloc_req = 1'b1;
    #1;
    check_zero("reset");
    alloc_req = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (5) step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 4'd0);
    step(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0);
    repeat (4) step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0100);
    f = 4'd0;
    for (int ph = 0; ph < 3; ph++) begin
      repeat (800) begin
        if ($urandom_range(0, 15) == 0)
          f = (ph == 1) ? 4'd0 : 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        step($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), f);
      end
      @(posedge CLK);
      #4;
      nRST = 1'b0;
      alloc_req = 1'b1;
      #1;
      check_zero("midreset");
      q.delete();
      model_reset();
      alloc_req = 1'b0; ack_valid = 1'b0; nack_valid = 1'b0;
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
    end
    repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("queue_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/resend_scheduler.md
Name: resend_scheduler

Overview:
- Tracks up to four in-flight transmitted packets, one per resend slot 0-3. These map to the RESEND_PACKET0..3 comma types.
- Allocates a slot when the TX side launches a packet and frees the slot on ACK.
- On NACK or ack timeout, schedules a resend by pulsing the per-slot resend write strobes into the arbitration buffer.
- Sits between the link-layer RX decoder (ACK/NACK reports) and the arbitration buffer's rsN_write / rsN_cnt_full interface.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles to wait for ACK/NACK after send or resend before forcing a resend.
- MAX_RETRIES, 3, resends allowed per packet before it is abandoned.
- TIMER_W, $clog2(TIMEOUT_CYCLES+1), timer width (derived, do not override).

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- nRST  input  1  reset, asynchronous, active-low.
- alloc_req  input  1  TX requests a slot for a newly launched packet.
- alloc_gnt  output  1  combinational grant: high when alloc_req is high and any slot is FREE.
- alloc_slot  output  2  granted slot index (lowest-numbered FREE slot); 0 when no grant.
- ack_valid  input  1  ACK received.
- ack_slot  input  2  slot the ACK refers to.
- nack_valid  input  1  NACK received.
- nack_slot  input  2  slot the NACK refers to.
- rs_cnt_full  input  4  per-slot resend counter full from the arbitration buffer; bit i = rs{i}_cnt_full.
- rs_write  output  4  one-hot resend pulse to the arbitration buffer, at most one bit per cycle.
- slot_busy  output  4  bit i high when slot i is not FREE.
- err_valid  output  1  one-cycle pulse when a packet is abandoned.
- err_slot  output  2  slot abandoned; valid with err_valid.

Behaviour:
- Reset (async, nRST low):
  - All slots FREE, timers 0, retry counts 0, round-robin pointer 0.
  - rs_write=0, err_valid=0, err_slot=0, slot_busy=0, alloc_gnt=0.
- Per-slot state is FREE, WAIT_ACK or RESEND_PEND, with a TIMER_W-bit down-timer and a 2-bit retry count.
- Allocation:
  - Grant is based on registered state. A slot freed in cycle N can first be granted in cycle N+1.
  - On grant, the slot becomes WAIT_ACK next cycle with timer=TIMEOUT_CYCLES and retry=0.
- WAIT_ACK:
  - Timer decrements by 1 each cycle.
  - ACK for the slot -> FREE.
  - Else NACK for the slot, or timer==1 (expiring this cycle) -> RESEND_PEND.
- RESEND_PEND:
  - Timer is held.
  - ACK for the slot -> FREE; the pending resend is cancelled.
  - NACK for the slot is ignored (already pending).
- Priority on the same slot in the same cycle: ACK over NACK over timeout.
- ACK or NACK naming a FREE slot is ignored, with no state change.
- Resend issue (single issue per cycle, registered output):
  - Candidates are slots in RESEND_PEND with rs_cnt_full[i]==0.
  - The search starts at the RR pointer and wraps 3->0. The pointer moves to winner+1 mod 4.
  - If the winner's retry < MAX_RETRIES:
    - rs_write[winner] pulses high for exactly one cycle (the cycle after selection).
    - The slot goes to WAIT_ACK with timer reload and retry+1.
  - If the winner's retry == MAX_RETRIES:
    - No rs_write.
    - err_valid=1 and err_slot=winner next cycle; the slot goes FREE.
  - A slot whose rs_cnt_full is high stays RESEND_PEND indefinitely, timer held, until the full flag drops.
- Simultaneous events:
  - Alloc, ACK, NACK and resend issue on distinct slots all take effect in the same cycle.
  - An ACK arriving the same cycle the slot wins resend selection cancels it: no rs_write, slot FREE.
- The timer never wraps. It saturates at 0 only in FREE.
- Reset mid-operation discards all tracking immediately. Any rs_write or err_valid pulse in progress is cut to 0.

Test Plan:
- Alloc x4 with no ACK: alloc_slot=0,1,2,3 on successive cycles, slot_busy=4'hF; a 5th alloc_req -> alloc_gnt=0.
- Alloc slot0, then ACK slot0 on cycle 10 -> slot_busy[0]=0 next cycle, no rs_write for the following 2*TIMEOUT_CYCLES.
- Alloc slot1, NACK slot1 -> rs_write=4'b0010 exactly 2 cycles after the NACK, one cycle wide, slot_busy[1] stays 1.
- Alloc slot2, no response, MAX_RETRIES=3:
  - rs_write[2] pulses at TIMEOUT_CYCLES+1, 2*TIMEOUT_CYCLES+2 and 3*(TIMEOUT_CYCLES+1) cycles after grant.
  - The next expiry gives err_valid=1 with err_slot=2, and slot_busy[2]=0.
- Slots 0-3 all NACKed in the same cycle:
  - rs_write = 0001, 0010, 0100, 1000 on 4 consecutive cycles (RR from pointer 0).
  - With rs_cnt_full=4'b0010 held, the sequence is 0001, 0100, 1000, then 0010 after the full flag drops.
- ACK slot3 in the same cycle slot3 becomes RESEND_PEND-selected -> no rs_write[3], slot_busy[3]=0. Assert nRST mid-sequence -> all outputs 0 asynchronously.
